// File: rtl/core_fifo_gray_ptr.sv
// rtl/core_fifo_gray_ptr.sv - FIFO pointer with Gray export, occupancy level and status flags
// Optional macro COREFIFO_GRAY_PIPE_EN registers the decoded remote pointer before the level subtraction.
module core_fifo_gray_ptr #(
    parameter int ADDRWIDTH    = 3,
    parameter int WR_SIDE      = 1,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic [ADDRWIDTH:0]   remote_gray,
    output logic [ADDRWIDTH:0]   ptr_gray,
    output logic [ADDRWIDTH-1:0] addr,
    output logic [ADDRWIDTH:0]   level,
    output logic                 full,
    output logic                 empty,
    output logic                 afull,
    output logic                 err
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [ADDRWIDTH:0] DEPTH     = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [ADDRWIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [ADDRWIDTH:0]   ptr_bin_q, ptr_bin_d;
    logic [ADDRWIDTH:0]   ptr_gray_q, ptr_gray_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [ADDRWIDTH:0]   level_q, level_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 afull_q, afull_d;
    logic                 err_q, err_d;
    logic [ADDRWIDTH:0]   remote_bin_c;
    logic [ADDRWIDTH:0]   remote_bin;
    logic                 blocked;
    logic                 accept;

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        remote_bin_c = '0;
        for (int i = 0; i <= ADDRWIDTH; i++) begin
            remote_bin_c[i] = ^(remote_gray >> i);
        end
    end

`ifdef COREFIFO_GRAY_PIPE_EN
    logic [ADDRWIDTH:0] remote_bin_q, remote_bin_d;

    always_comb begin
        remote_bin_d = remote_bin_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remote_bin_q <= '0;
        end else begin
            remote_bin_q <= remote_bin_d;
        end
    end

    assign remote_bin = remote_bin_q;
`else
    assign remote_bin = remote_bin_c;
`endif

    always_comb begin
        blocked    = (WR_SIDE != 0) ? full_q : empty_q;
        accept     = inc & ~blocked;
        err_d      = inc & blocked;
        ptr_bin_d  = ptr_bin_q + {{ADDRWIDTH{1'b0}}, accept};
        ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
        addr_d     = ptr_bin_d[ADDRWIDTH-1:0];
        // Flags come from the next-state pointer so a local accept shows up on the same edge.
        if (WR_SIDE != 0) begin
            level_d = ptr_bin_d - remote_bin;
        end else begin
            level_d = remote_bin - ptr_bin_d;
        end
        full_d  = (level_d == DEPTH);
        empty_d = (level_d == '0);
        afull_d = (level_d >= AFULL_LVL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            addr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            addr_q     <= addr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            err_q      <= err_d;
        end
    end

    assign ptr_gray = ptr_gray_q;
    assign addr     = addr_q;
    assign level    = level_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign afull    = afull_q;
    assign err      = err_q;

endmodule
